// File: rtl/spi_boot_pkg.sv
// Shared command codes, terminator word and FSM state encoding for the SPI boot slave.
package spi_boot_pkg;

  localparam logic [7:0]  CMD_READ  = 8'h01;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_SKIP
  } state_e;

endpackage

// File: rtl/spi_boot_sync.sv
// Multi-stage synchronizer for one SPI pin, plus an edge-detect register that
// yields single-cycle rise/fall pulses in the system clock domain.
module spi_boot_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: flops use non-blocking (<=) so each stage samples the pre-edge value of the
  // one before it; blocking assignments would collapse the chain into a single stage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q[STAGES-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/spi_boot_slave.sv
// SPI mode-0 boot slave: streams words into IMEM (cmd 0x02) and, when
// SPI_BOOT_READBACK_EN is defined, reads IMEM back word by word (cmd 0x01).
module spi_boot_slave
  import spi_boot_pkg::*;
#(
  parameter int AW          = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_prog,
  input  logic          i_csn,
  input  logic          i_sclk,
  input  logic          i_mosi,
  output logic          o_miso,
  output logic          o_mem_we,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // Chip select idles high, so its synchronizer resets high to avoid a false cs_fall.
  spi_boot_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_d(i_csn),
    .o_level(cs_lvl), .o_rise(cs_rise), .o_fall(cs_fall)
  );
  spi_boot_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_d(i_sclk),
    .o_level(sck_lvl), .o_rise(sck_rise), .o_fall(sck_fall)
  );
  spi_boot_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_d(i_mosi),
    .o_level(mosi_lvl), .o_rise(mosi_rise), .o_fall(mosi_fall)
  );

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   word_q, word_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef SPI_BOOT_READBACK_EN
  logic          mem_re_q, mem_re_d;
  logic          rd_cap_q, rd_cap_d;
  logic [31:0]   rdata_q, rdata_d;
`endif

  logic          cs_active, in_data, byte_done, word_done;
  logic [7:0]    rx_byte;
  logic [31:0]   rx_word;
  logic [AW:0]   addr_inc;
  logic          unused_sigs;

  assign cs_active = ~cs_lvl & i_prog;
  assign in_data   = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign rx_byte   = {rx_sh_q[6:0], mosi_lvl};
  assign rx_word   = {rx_byte, word_q};
  assign byte_done = sck_rise && cs_active && !cs_rise && (bit_cnt_q == 3'd7);
  assign word_done = byte_done && in_data && (byte_cnt_q == 2'd3);
  assign addr_inc  = {1'b0, addr_q} + {{(AW-2){1'b0}}, 3'b100};

  // NOTE: every *_d gets its hold/default value first; any branch that skipped an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wrap_d      = wrap_q;
    tx_sh_d     = tx_sh_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef SPI_BOOT_READBACK_EN
    mem_re_d    = 1'b0;
    rd_cap_d    = mem_re_q;
    rdata_d     = rdata_q;
`endif

    if (sck_rise && cs_active) begin
      rx_sh_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // The fall right after a byte's 8th rise must not shift: the next byte was just loaded.
    if (sck_fall && cs_active && (bit_cnt_q != 3'd0)) begin
      tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end

    if (byte_done && in_data) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = rx_byte;
        2'd1:    word_d[15:8]  = rx_byte;
        2'd2:    word_d[23:16] = rx_byte;
        default: word_d        = word_q;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        tx_sh_d = 8'h00;
        if (cs_fall && i_prog) begin
          state_d    = ST_CMD;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 2'd0;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          addr_d     = '0;
          wrap_d     = 1'b0;
          err_d      = 1'b0;
          byte_cnt_d = 2'd0;
          tx_sh_d    = 8'h00;
`ifdef SPI_BOOT_READBACK_EN
          rdata_d    = 32'h0;
`endif
          case (rx_byte)
            CMD_WRITE: begin
              state_d = ST_WRITE;
              tx_sh_d = rx_byte;
            end
`ifdef SPI_BOOT_READBACK_EN
            CMD_READ: state_d = ST_READ;
`endif
            default:  state_d = ST_SKIP;
          endcase
        end
      end
      ST_WRITE: begin
        if (byte_done) begin
          tx_sh_d = rx_byte;
        end
        if (word_done) begin
          if (rx_word == TERM_WORD) begin
            done_d  = 1'b1;
            state_d = ST_SKIP;
          end else begin
            // Once the counter has wrapped, writes are dropped but still consume an address.
            if (wrap_q) begin
              err_d = 1'b1;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = rx_word;
            end
            addr_d = addr_inc[AW-1:0];
            if (addr_inc[AW]) begin
              wrap_d = 1'b1;
            end
          end
        end
      end
`ifdef SPI_BOOT_READBACK_EN
      ST_READ: begin
        if (byte_done) begin
          case (byte_cnt_q)
            2'd0:    tx_sh_d = rdata_q[15:8];
            2'd1:    tx_sh_d = rdata_q[23:16];
            2'd2:    tx_sh_d = rdata_q[31:24];
            default: tx_sh_d = rdata_q[7:0];
          endcase
        end
        if (word_done) begin
          mem_re_d   = 1'b1;
          mem_addr_d = {rx_word[AW-1:2], 2'b00};
        end
        // Fresh read data arrives after the word boundary, so it overrides the byte-0 load.
        if (rd_cap_q) begin
          rdata_d = i_mem_rdata;
          tx_sh_d = i_mem_rdata[7:0];
        end
      end
`endif
      ST_SKIP: ;
      default: state_d = ST_IDLE;
    endcase

    if (cs_rise) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      word_d     = 24'h0;
      tx_sh_d    = 8'h00;
    end

    if (!i_prog) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      tx_sh_d    = 8'h00;
      mem_we_d   = 1'b0;
      done_d     = 1'b0;
`ifdef SPI_BOOT_READBACK_EN
      mem_re_d   = 1'b0;
      rd_cap_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      byte_cnt_q  <= 2'd0;
      word_q      <= 24'h0;
      addr_q      <= '0;
      wrap_q      <= 1'b0;
      tx_sh_q     <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SPI_BOOT_READBACK_EN
      mem_re_q    <= 1'b0;
      rd_cap_q    <= 1'b0;
      rdata_q     <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wrap_q      <= wrap_d;
      tx_sh_q     <= tx_sh_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SPI_BOOT_READBACK_EN
      mem_re_q    <= mem_re_d;
      rd_cap_q    <= rd_cap_d;
      rdata_q     <= rdata_d;
`endif
    end
  end

  assign o_miso      = tx_sh_q[7];
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;

`ifdef SPI_BOOT_READBACK_EN
  assign o_mem_re    = mem_re_q;
  assign unused_sigs = ^{sck_lvl, mosi_rise, mosi_fall};
`else
  assign o_mem_re    = 1'b0;
  assign unused_sigs = ^{sck_lvl, mosi_rise, mosi_fall, i_mem_rdata};
`endif

endmodule

// File: tb/tb_spi_boot_slave.sv
// Directed bench for spi_boot_slave: table-driven SPI sessions plus hand-written
// abort, overflow (second instance with AW=4) and mid-byte reset sequences.
module tb_spi_boot_slave;
  import spi_boot_pkg::*;

  localparam int HALF = 8;  // i_clk cycles per SCLK half-period

  logic        clk = 1'b0;
  logic        rstn, prog, csn, sclk, mosi;
  logic        miso, we, re, busy, done, err;
  logic [10:0] addr;
  logic [31:0] wdata, rdata;
  logic        miso4, we4, re4, busy4, done4, err4;
  logic [3:0]  addr4;
  logic [31:0] wdata4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_boot_slave #(.AW(11), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_prog(prog), .i_csn(csn), .i_sclk(sclk),
    .i_mosi(mosi), .o_miso(miso), .o_mem_we(we), .o_mem_re(re),
    .o_mem_addr(addr), .o_mem_wdata(wdata), .i_mem_rdata(rdata),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  spi_boot_slave #(.AW(4), .SYNC_STAGES(2)) dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_prog(prog), .i_csn(csn), .i_sclk(sclk),
    .i_mosi(mosi), .o_miso(miso4), .o_mem_we(we4), .o_mem_re(re4),
    .o_mem_addr(addr4), .o_mem_wdata(wdata4), .i_mem_rdata(32'h0),
    .o_busy(busy4), .o_done(done4), .o_err(err4)
  );

  // IMEM model: synchronous write, read data valid the cycle after o_mem_re
  logic [31:0] imem [0:511];
  initial begin
    for (int i = 0; i < 512; i++) imem[i] = 32'h0;
    rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (we) imem[addr[10:2]] <= wdata;
    if (re) rdata <= imem[addr[10:2]];
  end

  int          we_cnt = 0, re_cnt = 0, done_cnt = 0;
  logic [10:0] last_waddr = '0, last_raddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  waddr4_log [$];

  always @(posedge clk) begin
    if (we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= addr;
      last_wdata <= wdata;
    end
    if (re) begin
      re_cnt     <= re_cnt + 1;
      last_raddr <= addr;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (we4) waddr4_log.push_back(addr4);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_miso;
    int          exp_we;
    int          exp_re;
    int          exp_done;
    logic [10:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tab [$];

  function automatic vec_t mk(input logic [31:0] w, input logic [31:0] m, input int we_n,
                              input int re_n, input int done_n, input logic [10:0] a,
                              input logic [31:0] d);
    vec_t v;
    v.word = w; v.exp_miso = m; v.exp_we = we_n; v.exp_re = re_n;
    v.exp_done = done_n; v.exp_addr = a; v.exp_wdata = d;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [31:0] w, output logic [31:0] r);
    logic [7:0] rb;
    for (int b = 0; b < 4; b++) begin
      spi_byte(w[8*b +: 8], rb);
      r[8*b +: 8] = rb;
    end
  endtask

  task automatic cs_end();
    tick(HALF);
    csn = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic run_session(input logic p, input logic [7:0] cmd, input string tag);
    logic [7:0]  rb;
    logic [31:0] rw;
    int          w0, r0, d0;
    prog = p;
    tick(2);
    csn = 1'b0;
    spi_byte(cmd, rb);
    check({tag, "_cmd_miso"}, {24'h0, rb}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, {31'h0, p});
    foreach (tab[i]) begin
      w0 = we_cnt; r0 = re_cnt; d0 = done_cnt;
      spi_word(tab[i].word, rw);
      tick(4);
      check($sformatf("%s[%0d]_miso", tag, i), rw, tab[i].exp_miso);
      check($sformatf("%s[%0d]_we", tag, i), we_cnt - w0, tab[i].exp_we);
      check($sformatf("%s[%0d]_re", tag, i), re_cnt - r0, tab[i].exp_re);
      check($sformatf("%s[%0d]_done", tag, i), done_cnt - d0, tab[i].exp_done);
      if (tab[i].exp_we != 0) begin
        check($sformatf("%s[%0d]_waddr", tag, i), {21'h0, last_waddr}, {21'h0, tab[i].exp_addr});
        check($sformatf("%s[%0d]_wdata", tag, i), last_wdata, tab[i].exp_wdata);
      end
      if (tab[i].exp_re != 0) begin
        check($sformatf("%s[%0d]_raddr", tag, i), {21'h0, last_raddr}, {21'h0, tab[i].exp_addr});
      end
    end
    cs_end();
    check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    prog = 1'b1;
  endtask

  initial begin
    logic [7:0]  rb;
    logic [31:0] rw;
    int          w0, n4;

    rstn = 1'b0; prog = 1'b0; csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    check("rst_miso",  {31'h0, miso},  32'h0);
    check("rst_we",    {31'h0, we},    32'h0);
    check("rst_re",    {31'h0, re},    32'h0);
    check("rst_addr",  {21'h0, addr},  32'h0);
    check("rst_wdata", wdata,          32'h0);
    check("rst_busy",  {31'h0, busy},  32'h0);
    check("rst_done",  {31'h0, done},  32'h0);
    check("rst_err",   {31'h0, err},   32'h0);
    rstn = 1'b1;
    prog = 1'b1;
    tick(4);

    // Write two words then the terminator; MISO echoes the previous byte.
    tab.delete();
    tab.push_back(mk(32'h0000_0013, 32'h0000_1302, 1, 0, 0, 11'h000, 32'h0000_0013));
    tab.push_back(mk(32'h0010_0093, 32'h1000_9300, 1, 0, 0, 11'h004, 32'h0010_0093));
    tab.push_back(mk(TERM_WORD,     32'hFFFF_FF00, 0, 0, 1, 11'h000, 32'h0));
    run_session(1'b1, CMD_WRITE, "wr");

    // Readback: each word returns the data addressed by the previous word.
    tab.delete();
`ifdef SPI_BOOT_READBACK_EN
    tab.push_back(mk(32'h0000_0000, 32'h0000_0000, 0, 1, 0, 11'h000, 32'h0));
    tab.push_back(mk(32'h0000_0004, 32'h0000_0013, 0, 1, 0, 11'h004, 32'h0));
    tab.push_back(mk(32'h0000_0008, 32'h0010_0093, 0, 1, 0, 11'h008, 32'h0));
`else
    tab.push_back(mk(32'h0000_0000, 32'h0, 0, 0, 0, 11'h000, 32'h0));
    tab.push_back(mk(32'h0000_0004, 32'h0, 0, 0, 0, 11'h000, 32'h0));
    tab.push_back(mk(32'h0000_0008, 32'h0, 0, 0, 0, 11'h000, 32'h0));
`endif
    run_session(1'b1, CMD_READ, "rd");

    // Abort mid-word, then a fresh write lands at address 0 again.
    w0 = we_cnt;
    csn = 1'b0;
    spi_byte(CMD_WRITE, rb);
    spi_byte(8'hAA, rb);
    spi_byte(8'hBB, rb);
    cs_end();
    check("abort_we", we_cnt - w0, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    tab.delete();
    tab.push_back(mk(32'hDEAD_BEEF, 32'hADBE_EF02, 1, 0, 0, 11'h000, 32'hDEAD_BEEF));
    run_session(1'b1, CMD_WRITE, "rewrite");

    // Unknown command is skipped; with PROG low nothing responds.
    tab.delete();
    tab.push_back(mk(32'h1234_5678, 32'h0, 0, 0, 0, 11'h000, 32'h0));
    run_session(1'b1, 8'h5A, "skip");
    tab.delete();
    tab.push_back(mk(32'h1111_1111, 32'h0, 0, 0, 0, 11'h000, 32'h0));
    tab.push_back(mk(TERM_WORD,     32'h0, 0, 0, 0, 11'h000, 32'h0));
    run_session(1'b0, CMD_WRITE, "noprog");

    // Overflow: the AW=4 instance holds 4 words, the 5th write is dropped.
    w0 = we_cnt;
    n4 = waddr4_log.size();
    tick(2);
    csn = 1'b0;
    spi_byte(CMD_WRITE, rb);
    for (int i = 0; i < 5; i++) spi_word(32'h1000_0000 + i, rw);
    tick(4);
    check("ovf_we4_count", waddr4_log.size() - n4, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (n4 + i < waddr4_log.size())
        check($sformatf("ovf_addr4[%0d]", i), {28'h0, waddr4_log[n4 + i]}, 32'(4 * i));
    end
    check("ovf_err4", {31'h0, err4}, 32'h1);
    check("ovf_we_aw11", we_cnt - w0, 32'd5);
    check("ovf_last_addr_aw11", {21'h0, last_waddr}, 32'h10);
    check("ovf_err_aw11", {31'h0, err}, 32'h0);
    cs_end();
    check("ovf_err4_sticky", {31'h0, err4}, 32'h1);
    csn = 1'b0;
    spi_byte(8'h5A, rb);
    tick(4);
    check("ovf_err4_cleared", {31'h0, err4}, 32'h0);
    cs_end();

    // Reset in the middle of a byte.
    csn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    #3;
    rstn = 1'b0;
    #1;
    check("mid_rst_miso",  {31'h0, miso}, 32'h0);
    check("mid_rst_we",    {31'h0, we},   32'h0);
    check("mid_rst_re",    {31'h0, re},   32'h0);
    check("mid_rst_addr",  {21'h0, addr}, 32'h0);
    check("mid_rst_wdata", wdata,         32'h0);
    check("mid_rst_busy",  {31'h0, busy}, 32'h0);
    check("mid_rst_done",  {31'h0, done}, 32'h0);
    check("mid_rst_err",   {31'h0, err},  32'h0);
    csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(4);
    rstn = 1'b1;
    tick(4);
    tab.delete();
    tab.push_back(mk(32'hCAFE_F00D, 32'hFEF0_0D02, 1, 0, 0, 11'h000, 32'hCAFE_F00D));
    tab.push_back(mk(TERM_WORD,     32'hFFFF_FFCA, 0, 0, 1, 11'h000, 32'h0));
    run_session(1'b1, CMD_WRITE, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
